multiplier: RTL and testbench
=============================

# multiplier

Sequential shift-add multiply-accumulate unit that computes PRODUCT = QUOTIENT × DIVISOR + REMAINDER. It is the inverse of `divider`. Its operand widths and START/DONE handshake match that block, so a `divider` result fed straight back must reproduce the original 9-bit dividend. It sits beside `divider` in the capstone datapath as the self-check and reconstruction path.

## Interface
Parameters:
- QW, 4: multiplier (QUOTIENT) width.
- DW, 5: multiplicand (DIVISOR) and REMAINDER width.
- PW, 9: PRODUCT width. Must satisfy (2^QW−1)(2^DW−1)+(2^DW−1) < 2^PW; the defaults give 496 < 512.

Ports:
- CLK, input, 1: single clock; all state updates on the rising edge.
- RESET_N, input, 1: reset, synchronous and active-low; sampled on CLK rising edge.
- START, input, 1: level request; sampled only in IDLE and DONE.
- QUOTIENT, input, QW: multiplier operand; captured when a request is accepted.
- DIVISOR, input, DW: multiplicand operand; captured when a request is accepted.
- REMAINDER, input, DW: addend; captured when a request is accepted.
- PRODUCT, output, PW: registered result.
- DONE, output, 1: registered; high while in the DONE state.

## Operation
- States: IDLE, RUN, DONE. Step counter is 2 bits (log2 QW).
- RESET_N low at an edge:
  - state becomes IDLE, PRODUCT becomes 0, DONE becomes 0, internal registers clear;
  - reset has priority over every other condition.
- IDLE, START=1 at an edge (the acceptance edge):
  - ACC ← zero-extended REMAINDER; MCAND ← DIVISOR; MPLR ← QUOTIENT; count ← 0;
  - go to RUN.
- IDLE, START=0: hold. PRODUCT keeps its last value.
- RUN, one step per edge:
  - if MPLR[0]=1, ACC ← ACC + (MCAND << count), computed at PW bits with no carry-out possible;
  - MPLR ← MPLR >> 1; count ← count + 1.
  - On the QW-th step: PRODUCT ← final ACC, go to DONE.
- DONE:
  - DONE=1 and PRODUCT holds stable;
  - stay while START=1;
  - START=0 at an edge → IDLE, DONE drops, PRODUCT retained.
- Operand inputs may change freely after the acceptance edge without affecting the result.
- START is ignored in RUN. Deasserting START mid-run does not abort.
- A new operation needs START low for at least one edge in DONE, then high in IDLE.
- Zero operands need no special case: QUOTIENT=0 or DIVISOR=0 gives PRODUCT=REMAINDER.

## Timing
- Acceptance edge is E0; RUN steps occur at E1..E4. DONE and PRODUCT are valid after E4 (latency QW = 4 cycles).
- PRODUCT updates only at the final RUN edge and on reset. It never shows partial sums.
- Minimum back-to-back cycle:
  - accept, 4 run edges, 1 edge in DONE with START=0, then re-accept;
  - 6 edges in total.
- Reset asserted during RUN or DONE: outputs are 0 after that edge and no result is produced. START=1 at the first edge with RESET_N high is accepted normally.
- Simultaneous START=1 and RESET_N=0: reset wins and the request is lost.

## Configuration
- MULTIPLIER_ACCUM_EN defined:
  - REMAINDER is captured into ACC at acceptance;
  - PRODUCT = QUOTIENT × DIVISOR + REMAINDER.
- MULTIPLIER_ACCUM_EN not defined:
  - ACC initialises to 0 and REMAINDER is ignored; the port stays present;
  - PRODUCT = QUOTIENT × DIVISOR, same latency.

## Test plan
- Reconstruction with ACCUM_EN: QUOTIENT=13, DIVISOR=10, REMAINDER=5, START=1 → DONE=1 exactly 4 edges after acceptance, PRODUCT=135.
- Small operands: QUOTIENT=1, DIVISOR=4, REMAINDER=2 → PRODUCT=6. Then QUOTIENT=0, DIVISOR=31, REMAINDER=7 → PRODUCT=7.
- Maximum values: QUOTIENT=15, DIVISOR=31, REMAINDER=31 → PRODUCT=496. Without MULTIPLIER_ACCUM_EN the same stimulus gives 465.
- Handshake:
  - hold START=1 for 10 edges after DONE → DONE stays 1, PRODUCT stays constant, no restart;
  - drop START for 1 edge, change operands, raise START → new result 4 edges later;
  - operand changes during RUN have no effect.
- Reset mid-operation: RESET_N=0 at the second RUN edge → PRODUCT=0 and DONE=0 after that edge. Release reset with START=1 → a fresh operation completes in 4 cycles.
- Exhaustive reconstruction sweep: for all QUOTIENT 0..15, DIVISOR 1..31, and REMAINDER < DIVISOR, PRODUCT must equal QUOTIENT×DIVISOR+REMAINDER.

Source files
------------

// File: rtl/multiplier.sv
// Shift-add multiply-accumulate: PRODUCT = QUOTIENT * DIVISOR (+ REMAINDER when
// MULTIPLIER_ACCUM_EN is defined), one partial product per clock, QW clocks per result.
//
// state   | meaning
// IDLE    | waiting for START, PRODUCT holds last result
// RUN     | one shift-add step per edge, QW steps total
// DONE    | DONE high, PRODUCT stable, waits for START low
module multiplier #(
  parameter int QW = 4,
  parameter int DW = 5,
  parameter int PW = 9
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic [QW-1:0] QUOTIENT,
  input  logic [DW-1:0] DIVISOR,
  input  logic [DW-1:0] REMAINDER,
  output logic [PW-1:0] PRODUCT,
  output logic          DONE
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [QW-1:0] mplr_q, mplr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] product_q, product_d;
  logic          done_q, done_d;

  logic [PW-1:0] acc_init;
  logic [PW-1:0] addend;
  logic [PW-1:0] acc_step;

`ifdef MULTIPLIER_ACCUM_EN
  assign acc_init = PW'(REMAINDER);
`else
  // REMAINDER stays on the port so both builds share one pinout.
  logic unused_remainder;
  assign unused_remainder = ^REMAINDER;
  assign acc_init = '0;
`endif

  // PW is wide enough for the full result, so the sum never carries out.
  assign addend   = PW'(mcand_q) << count_q;
  assign acc_step = mplr_q[0] ? (acc_q + addend) : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          acc_d   = acc_init;
          mcand_d = DIVISOR;
          mplr_d  = QUOTIENT;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = acc_step;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          product_d = acc_step;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!START) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign PRODUCT = product_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: cycle-level behavioural model compared every cycle,
// plus literal expectations from the test plan, a full sweep and random traffic.
module tb_multiplier;
  localparam int QW = 4;
  localparam int DW = 5;
  localparam int PW = 9;
`ifdef MULTIPLIER_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic [QW-1:0] QUOTIENT = '0;
  logic [DW-1:0] DIVISOR = '0;
  logic [DW-1:0] REMAINDER = '0;
  logic [PW-1:0] PRODUCT;
  logic          DONE;

  multiplier #(.QW(QW), .DW(DW), .PW(PW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .QUOTIENT(QUOTIENT), .DIVISOR(DIVISOR), .REMAINDER(REMAINDER),
    .PRODUCT(PRODUCT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  function automatic int expect_of(int q, int d, int r);
    return q * d + (ACC ? r : 0);
  endfunction

  // Behavioural model: a request takes QW edges, then the result is shown until START drops.
  int m_pending = 0;
  int m_result = 0;
  int m_product = 0;
  bit m_done = 1'b0;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      m_pending = 0;
      m_product = 0;
      m_done    = 1'b0;
    end else if (m_pending > 0) begin
      m_pending = m_pending - 1;
      if (m_pending == 0) begin
        m_product = m_result;
        m_done    = 1'b1;
      end
    end else if (m_done) begin
      if (!START) m_done = 1'b0;
    end else if (START) begin
      m_pending = QW;
      m_result  = expect_of(int'(QUOTIENT), int'(DIVISOR), int'(REMAINDER));
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      total++;
      if (DONE !== m_done || PRODUCT !== m_product[PW-1:0]) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t DONE=%b PRODUCT=%0d required DONE=%b PRODUCT=%0d",
                 $time, DONE, PRODUCT, m_done, m_product);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Accept one request from IDLE and wait (bounded) for DONE; START is left high.
  task automatic run_op(input int q, input int d, input int r, input bit scramble,
                        output int lat);
    QUOTIENT  = q[QW-1:0];
    DIVISOR   = d[DW-1:0];
    REMAINDER = r[DW-1:0];
    START     = 1'b1;
    step();
    lat = 0;
    while (DONE !== 1'b1 && lat < 20) begin
      if (scramble) begin
        QUOTIENT  = QW'($urandom);
        DIVISOR   = DW'($urandom);
        REMAINDER = DW'($urandom);
        START     = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    chk("latency", lat, QW);
  endtask

  task automatic finish_op();
    START = 1'b0;
    step();
  endtask

  int lat;
  int e;

  initial begin
    RESET_N = 1'b0;
    START   = 1'b1;
    step();
    check_en = 1'b1;
    step();
    chk("reset_product", int'(PRODUCT), 0);
    chk("reset_done", int'(DONE), 0);
    START   = 1'b0;
    RESET_N = 1'b1;
    step();
    chk("idle_done", int'(DONE), 0);

    run_op(13, 10, 5, 1'b0, lat);
    chk("recon_135", int'(PRODUCT), ACC ? 135 : 130);
    chk("recon_done", int'(DONE), 1);
    finish_op();

    run_op(1, 4, 2, 1'b0, lat);
    chk("small_6", int'(PRODUCT), ACC ? 6 : 4);
    finish_op();
    run_op(0, 31, 7, 1'b0, lat);
    chk("zero_q", int'(PRODUCT), ACC ? 7 : 0);
    finish_op();

    run_op(15, 31, 31, 1'b0, lat);
    chk("max_val", int'(PRODUCT), ACC ? 496 : 465);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_done", int'(DONE), 1);
      chk("hold_product", int'(PRODUCT), ACC ? 496 : 465);
    end
    START     = 1'b0;
    QUOTIENT  = 4'd2;
    DIVISOR   = 5'd3;
    REMAINDER = 5'd1;
    step();
    chk("drop_done", int'(DONE), 0);
    chk("drop_retain", int'(PRODUCT), ACC ? 496 : 465);
    run_op(3, 7, 2, 1'b0, lat);
    chk("restart", int'(PRODUCT), ACC ? 23 : 21);
    finish_op();

    run_op(9, 11, 3, 1'b1, lat);
    chk("operand_churn", int'(PRODUCT), ACC ? 102 : 99);
    finish_op();

    QUOTIENT  = 4'd5;
    DIVISOR   = 5'd6;
    REMAINDER = 5'd1;
    START     = 1'b1;
    step();
    step();
    RESET_N = 1'b0;
    step();
    chk("midrun_rst_product", int'(PRODUCT), 0);
    chk("midrun_rst_done", int'(DONE), 0);
    RESET_N = 1'b1;
    run_op(2, 3, 1, 1'b0, lat);
    chk("after_reset", int'(PRODUCT), ACC ? 7 : 6);
    finish_op();

    for (int q = 0; q < 16; q++) begin
      for (int d = 1; d < 32; d++) begin
        for (int r = 0; r < d; r++) begin
          run_op(q, d, r, 1'b0, lat);
          chk("sweep", int'(PRODUCT), expect_of(q, d, r));
          finish_op();
        end
      end
    end

    for (int n = 0; n < 200; n++) begin
      int q, d, r, gap;
      q   = int'($urandom_range(0, 15));
      d   = int'($urandom_range(0, 31));
      r   = int'($urandom_range(0, 31));
      gap = int'($urandom_range(0, 3));
      run_op(q, d, r, 1'($urandom_range(0, 1)), lat);
      e = expect_of(q, d, r);
      chk("random", int'(PRODUCT), e);
      for (int g = 0; g < gap; g++) step();
      finish_op();
      for (int g = 0; g < gap; g++) step();
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
